// File: rtl/gx4000_cpr_loader.sv
// gx4000_cpr_loader
// Parses a .cpr (RIFF "AMS!") cartridge image from the ioctl download stream
// and turns every "cbNN" bank chunk into byte writes at
// BASE_ADDR + bank*16384 + offset. Unknown or out-of-range chunks are skipped.
//
// Ports:
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   ioctl_download/index      download framing; a cartridge load starts on the
//                             rising edge of ioctl_download with index CART_INDEX
//   ioctl_wr, ioctl_dout      one byte per strobe, in file order
//   cart_addr/data/wr         SDRAM byte write, one cycle after the ioctl_wr sample
//   busy, done, error         load status (done/error sticky until next load)
//   bank_count                distinct bank chunks seen (saturates at 32)
//   chk_sum                   only with GX4000_CPR_CHECKSUM_EN: mod-65536 sum of
//                             every byte written to the cartridge region
module gx4000_cpr_loader #(
  parameter logic [7:0]  CART_INDEX = 8'h03,
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter int          MAX_BANKS  = 32
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic [24:0] cart_addr,
  output logic [7:0]  cart_data,
  output logic        cart_wr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  bank_count
`ifdef GX4000_CPR_CHECKSUM_EN
  ,
  output logic [15:0] chk_sum
`endif
);

  // The seen mask and bank field are 32 entries wide, so larger values clamp.
  localparam int         MAX_B       = (MAX_BANKS > 32) ? 32 : MAX_BANKS;
  localparam logic [6:0] MAX_BANKS_W = 7'(MAX_B);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_CID   = 3'd2,
    S_CSIZE = 3'd3,
    S_DATA  = 3'd4,
    S_SKIP  = 3'd5,
    S_PAD   = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // Expected header byte: {must_match, ascii}. Bytes 4-7 (RIFF size) are free.
  function automatic logic [8:0] hdr_expect(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_expect = {1'b1, 8'h52};  // R
      4'd1:    hdr_expect = {1'b1, 8'h49};  // I
      4'd2:    hdr_expect = {1'b1, 8'h46};  // F
      4'd3:    hdr_expect = {1'b1, 8'h46};  // F
      4'd8:    hdr_expect = {1'b1, 8'h41};  // A
      4'd9:    hdr_expect = {1'b1, 8'h4D};  // M
      4'd10:   hdr_expect = {1'b1, 8'h53};  // S
      4'd11:   hdr_expect = {1'b1, 8'h21};  // !
      default: hdr_expect = {1'b0, 8'h00};
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
  endfunction

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s, cnt_inc_s;
  logic [31:0] size_r, size_s;
  logic [4:0]  bank_r, bank_s;
  logic        id_ok_r, id_ok_s;
  logic [3:0]  tens_r, tens_s;
  logic [31:0] seen_r, seen_s;
  logic        dl_q_r;
  logic [24:0] cart_addr_r, cart_addr_s;
  logic [7:0]  cart_data_r, cart_data_s;
  logic        cart_wr_r, cart_wr_s;
  logic        busy_r, busy_s, done_r, done_s, error_r, error_s;
  logic [5:0]  bank_count_r, bank_count_s;
  logic        start_s, fall_s, mark_s;
  logic [8:0]  hdr_s;
  logic [6:0]  bank_val_s;
`ifdef GX4000_CPR_CHECKSUM_EN
  logic [15:0] chk_sum_r, chk_sum_s;
`endif

  assign start_s = ioctl_download & ~dl_q_r & (ioctl_index == CART_INDEX);
  assign fall_s  = ~ioctl_download & dl_q_r & busy_r;

  // Next-state and output computation for the chunk parser.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    size_s       = size_r;
    bank_s       = bank_r;
    id_ok_s      = id_ok_r;
    tens_s       = tens_r;
    seen_s       = seen_r;
    bank_count_s = bank_count_r;
    busy_s       = busy_r;
    done_s       = done_r;
    error_s      = error_r;
    cart_addr_s  = cart_addr_r;
    cart_data_s  = cart_data_r;
    cart_wr_s    = 1'b0;
    mark_s       = 1'b0;
    cnt_inc_s    = cnt_r + 32'd1;
    hdr_s        = hdr_expect(cnt_r[3:0]);
    bank_val_s   = ({3'd0, tens_r} * 7'd10) + {3'd0, ioctl_dout[3:0]};
`ifdef GX4000_CPR_CHECKSUM_EN
    chk_sum_s    = chk_sum_r;
`endif

    if (start_s) begin
      state_s      = S_HDR;
      cnt_s        = 32'd0;
      busy_s       = 1'b1;
      done_s       = 1'b0;
      error_s      = 1'b0;
      bank_count_s = 6'd0;
      seen_s       = 32'd0;
`ifdef GX4000_CPR_CHECKSUM_EN
      chk_sum_s    = 16'd0;
`endif
    end else begin
      if (ioctl_wr) begin
        case (state_r)
          S_HDR: begin
            if (hdr_s[8] && (ioctl_dout != hdr_s[7:0])) begin
              state_s = S_ERR;
              busy_s  = 1'b0;
              error_s = 1'b1;
            end else if (cnt_r == 32'd11) begin
              state_s = S_CID;
              cnt_s   = 32'd0;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end
          S_CID: begin
            // id_ok accumulates "c","b",digit,digit and finally the range test
            case (cnt_r[1:0])
              2'd0: id_ok_s = (ioctl_dout == 8'h63);
              2'd1: id_ok_s = id_ok_r & (ioctl_dout == 8'h62);
              2'd2: begin
                id_ok_s = id_ok_r & is_digit(ioctl_dout);
                tens_s  = ioctl_dout[3:0];
              end
              default: begin
                id_ok_s = id_ok_r & is_digit(ioctl_dout) & (bank_val_s < MAX_BANKS_W);
                bank_s  = bank_val_s[4:0];
              end
            endcase
            if (cnt_r[1:0] == 2'd3) begin
              state_s = S_CSIZE;
              cnt_s   = 32'd0;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end
          S_CSIZE: begin
            case (cnt_r[1:0])
              2'd0:    size_s[7:0]   = ioctl_dout;
              2'd1:    size_s[15:8]  = ioctl_dout;
              2'd2:    size_s[23:16] = ioctl_dout;
              default: size_s[31:24] = ioctl_dout;
            endcase
            if (cnt_r[1:0] == 2'd3) begin
              cnt_s = 32'd0;
              if (size_s == 32'd0) begin
                // empty bank chunk still counts as present
                state_s = S_CID;
                mark_s  = id_ok_r;
              end else if (id_ok_r) begin
                state_s = S_DATA;
              end else begin
                state_s = S_SKIP;
              end
            end else begin
              cnt_s = cnt_inc_s;
            end
          end
          S_DATA, S_SKIP: begin
            if ((state_r == S_DATA) && (cnt_r < 32'd16384)) begin
              cart_wr_s   = 1'b1;
              cart_addr_s = BASE_ADDR + {6'd0, bank_r, cnt_r[13:0]};
              cart_data_s = ioctl_dout;
`ifdef GX4000_CPR_CHECKSUM_EN
              chk_sum_s   = chk_sum_r + {8'd0, ioctl_dout};
`endif
            end else begin
              cart_wr_s = 1'b0;
            end
            mark_s = (state_r == S_DATA) && (cnt_r == 32'd0);
            if (cnt_inc_s == size_r) begin
              cnt_s   = 32'd0;
              state_s = size_r[0] ? S_PAD : S_CID;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end
          S_PAD: begin
            state_s = S_CID;
            cnt_s   = 32'd0;
          end
          default: state_s = state_r;  // IDLE and ERR ignore bytes
        endcase
      end else begin
        state_s = state_r;
      end

      if (mark_s && !seen_r[bank_r]) begin
        seen_s[bank_r] = 1'b1;
        bank_count_s   = (bank_count_r == 6'd32) ? bank_count_r : bank_count_r + 6'd1;
      end else begin
        seen_s = seen_s;
      end

      // End of download judged on the state after this cycle's byte.
      if (fall_s) begin
        if ((state_s == S_CID) && (cnt_s == 32'd0) && (bank_count_s != 6'd0)) begin
          done_s = 1'b1;
        end else begin
          error_s = 1'b1;
        end
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 32'd0;
      size_r       <= 32'd0;
      bank_r       <= 5'd0;
      id_ok_r      <= 1'b0;
      tens_r       <= 4'd0;
      seen_r       <= 32'd0;
      dl_q_r       <= 1'b0;
      cart_addr_r  <= 25'd0;
      cart_data_r  <= 8'd0;
      cart_wr_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      bank_count_r <= 6'd0;
`ifdef GX4000_CPR_CHECKSUM_EN
      chk_sum_r    <= 16'd0;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      size_r       <= size_s;
      bank_r       <= bank_s;
      id_ok_r      <= id_ok_s;
      tens_r       <= tens_s;
      seen_r       <= seen_s;
      dl_q_r       <= ioctl_download;
      cart_addr_r  <= cart_addr_s;
      cart_data_r  <= cart_data_s;
      cart_wr_r    <= cart_wr_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
      bank_count_r <= bank_count_s;
`ifdef GX4000_CPR_CHECKSUM_EN
      chk_sum_r    <= chk_sum_s;
`endif
    end
  end

  assign cart_addr  = cart_addr_r;
  assign cart_data  = cart_data_r;
  assign cart_wr    = cart_wr_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign bank_count = bank_count_r;
`ifdef GX4000_CPR_CHECKSUM_EN
  assign chk_sum    = chk_sum_r;
`endif

endmodule

// File: doc/gx4000_cpr_loader.md
Name: gx4000_cpr_loader

Overview:
- Upstream feeder for the Plus-mode cartridge path.
- Parses a `.cpr` (RIFF "AMS!") cartridge image arriving on the MiSTer ioctl download stream.
- Converts "cbNN" bank chunks into linear byte writes to the cartridge SDRAM region, at `BASE_ADDR + bank*16384 + offset`.
- Reports load status to the Plus-mode top level.

Parameters:
- CART_INDEX, 8'h03, ioctl_index value that identifies a cartridge download.
- BASE_ADDR, 25'h0000000, SDRAM byte address of bank 0.
- MAX_BANKS, 32, banks accepted (cb00..cb31); higher-numbered chunks are skipped.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  file type of current download
- ioctl_wr  in  1  one-cycle strobe, byte valid on ioctl_dout
- ioctl_dout  in  8  download byte
- cart_addr  out  25  SDRAM write address
- cart_data  out  8  SDRAM write data
- cart_wr  out  1  one-cycle write strobe
- busy  out  1  parse in progress
- done  out  1  image loaded successfully (sticky until next load)
- error  out  1  malformed or truncated image (sticky until next load)
- bank_count  out  6  number of distinct bank chunks written

Behaviour:
- Reset (reset_n=0, async): cart_addr=0, cart_data=0, cart_wr=0, busy=0, done=0, error=0, bank_count=0, state=IDLE.
- Start:
  - Trigger is a rising edge of ioctl_download while ioctl_index==CART_INDEX.
  - Clears done, error and bank_count; sets busy=1; goes to HDR with byte count 0.
  - Downloads with any other index are ignored entirely.
- Only ioctl_wr strobes advance the parser; ioctl_addr is not used (bytes arrive in order).
- States:
  - IDLE: wait for start.
  - HDR: 12 bytes. Bytes 0-3 must be "RIFF"; bytes 4-7 (RIFF size) are ignored; bytes 8-11 must be "AMS!". Any mismatch -> ERR at that byte.
  - CID: 4 bytes of chunk id. It is a valid bank if the bytes are 'c','b',d1,d0 with d1,d0 ASCII '0'-'9' and value = 10*d1+d0 < MAX_BANKS. Otherwise the chunk is unknown.
  - CSIZE: 4 bytes, little-endian 32-bit chunk size.
    - Size 0 -> CID (bank_count still increments for a valid bank).
    - Otherwise -> DATA if the id is a valid bank, else SKIP.
  - DATA: each byte produces one write.
    - Offsets below 16384: cart_addr = BASE_ADDR + {bank,14'b0} + offset, cart_data = byte, cart_wr=1 the cycle after the ioctl_wr sample.
    - Offsets >= 16384 are consumed without a write.
    - After the last byte: odd size -> PAD, even size -> CID.
  - SKIP: consume size bytes with no writes; then PAD if size odd, else CID.
  - PAD: consume 1 byte, no write -> CID.
  - ERR: error=1, busy=0; no further writes until next start.
- bank_count increments at the first byte of a valid bank chunk, or at CSIZE completion for a zero-size chunk, only if that bank has not already been seen (32-bit seen mask). Saturates at 32. A duplicate bank overwrites its SDRAM data without incrementing.
- End (falling edge of ioctl_download while busy):
  - done=1 if state==CID with CID byte count 0 and bank_count>0.
  - Otherwise error=1.
  - busy=0 in both cases; state -> IDLE.
- Simultaneous ioctl_wr and download fall in the same cycle: the byte is processed first, then the end check uses the resulting state.
- New start while busy restarts cleanly from HDR.
- cart_wr is never asserted on consecutive cycles unless ioctl_wr is.
- Latency is exactly 1 cycle from ioctl_wr to cart_wr.

Optional Feature:
- Macro: GX4000_CPR_CHECKSUM_EN.
- Defined:
  - Adds output port chk_sum[15:0], a running modulo-65536 sum of all written bytes (cart_wr cycles only).
  - Cleared at start and by reset; holds its value after done/error.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Valid image, "RIFF",size,"AMS!", then "cb00" size 16384 with bytes = offset[7:0], then "cb01" size 16384 -> 32768 writes; last write addr BASE+0x7FFF with data 0xFF; done=1, error=0, bank_count=2.
- Header byte 8 = 'X' instead of 'A' -> error=1 at that byte, busy=0, zero cart_wr pulses.
- Chunk "fmt " size 3 followed by "cb05" size 2 (0xAA,0xBB) -> 4 skipped bytes (3 data + 1 pad); writes 0xAA@BASE+0x14000 and 0xBB@BASE+0x14001; done=1, bank_count=1.
- Download ends 100 bytes into "cb00" data -> error=1, done=0; exactly 100 writes issued.
- Duplicate "cb02" chunks, then "cb40" size 4 -> second cb02 overwrites its data; cb40 produces no writes; bank_count=1, done=1.
- reset_n pulled low mid-DATA -> all outputs 0 immediately; a subsequent full valid load completes with done=1. With GX4000_CPR_CHECKSUM_EN: a single "cb00" of 16384×0x01 gives chk_sum=0x4000.
